// File: rtl/pe_cfg_if.sv
// pe_cfg_if: the data, weight-chain and control signals of one pe_cfg
// processing element. Each PE gets its own instance. A bench or an array
// wrapper ties act_o to the right neighbour and psum_o/w_o to the PE below.
//   slave  : the PE side (pe_cfg uses this modport)
//   master : the side that drives the PE inputs and watches its outputs
interface pe_cfg_if #(
    parameter int DWIDTH = 8,
    parameter int PWIDTH = 24
);
    logic              enable;
    logic              mode;
    logic [DWIDTH-1:0] act_i;
    logic              act_vld_i;
    logic [DWIDTH-1:0] act_o;
    logic              act_vld_o;
    logic [PWIDTH-1:0] psum_i;
    logic              psum_vld_i;
    logic [PWIDTH-1:0] psum_o;
    logic              psum_vld_o;
    logic [DWIDTH-1:0] w_i;
    logic [DWIDTH-1:0] w_o;
    logic              w_shift;
    logic              w_swap;
    logic              clr_acc;
    logic              drain_i;
    logic              ovf_o;

    modport slave (
        input  enable, mode, act_i, act_vld_i, psum_i, psum_vld_i, w_i,
               w_shift, w_swap, clr_acc, drain_i,
        output act_o, act_vld_o, psum_o, psum_vld_o, w_o, ovf_o
    );

    modport master (
        output enable, mode, act_i, act_vld_i, psum_i, psum_vld_i, w_i,
               w_shift, w_swap, clr_acc, drain_i,
        input  act_o, act_vld_o, psum_o, psum_vld_o, w_o, ovf_o
    );
endinterface

// File: rtl/pe_cfg.sv
// pe_cfg: configurable systolic-array processing element.
//   mode 0 (WS): the weight stays in the active register and psums flow down
//   the column with the product added.
//   mode 1 (OS): the PE accumulates locally using the streaming weight w_i.
//   A drain_i pulse broadcast to the column shifts the accumulators out
//   through psum_o, bottom row first.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous, active-low reset
//   bus      pe_cfg_if.slave: activations, psums, weight chain, control, ovf_o
// Parameters: DWIDTH operand width, PWIDTH psum width (>= 2*DWIDTH),
//   SIGNED two's-complement arithmetic, SATURATE clamp instead of wrap.
module pe_cfg #(
    parameter int DWIDTH   = 8,
    parameter int PWIDTH   = 24,
    parameter bit SIGNED   = 1'b1,
    parameter bit SATURATE = 1'b1
) (
    input  logic    clk,
    input  logic    reset_n,
    pe_cfg_if.slave bus
);
    typedef enum logic {ST_ACC, ST_DRAIN} state_t;

    state_t              state, state_nxt;
    logic [DWIDTH-1:0]   shadow, w_act, w_sel;
    logic [2*DWIDTH-1:0] prod;
    logic [PWIDTH-1:0]   prod_ext, ws_addend;
    logic [PWIDTH-1:0]   acc, acc_nxt;
    logic [PWIDTH-1:0]   psum_q, psum_nxt;
    logic                pvld_q, pvld_nxt;
    logic                ovf_q, ovf_nxt;
    logic [DWIDTH-1:0]   act_q;
    logic                act_vld_q;
    logic [PWIDTH:0]     ws_sum, acc_sum;   // {overflow, result}
    logic                restart;

    // Add at PWIDTH+1 bits so the true sum is always representable. The MSB
    // of the return value flags an out-of-range sum, and the low bits are
    // either the clamped sum or the sum modulo 2^PWIDTH.
    function automatic logic [PWIDTH:0] add_chk(input logic [PWIDTH-1:0] a,
                                                input logic [PWIDTH-1:0] b);
        logic [PWIDTH:0]   s;
        logic              ov;
        logic [PWIDTH-1:0] r;
        if (SIGNED) begin
            s  = {a[PWIDTH-1], a} + {b[PWIDTH-1], b};
            ov = s[PWIDTH] ^ s[PWIDTH-1];
            if (ov && SATURATE)
                r = s[PWIDTH] ? {1'b1, {(PWIDTH-1){1'b0}}} : {1'b0, {(PWIDTH-1){1'b1}}};
            else
                r = s[PWIDTH-1:0];
        end else begin
            s  = {1'b0, a} + {1'b0, b};
            ov = s[PWIDTH];
            r  = (ov && SATURATE) ? {PWIDTH{1'b1}} : s[PWIDTH-1:0];
        end
        return {ov, r};
    endfunction

    // OS multiplies by the streaming weight. WS uses the swapped-in weight.
    assign w_sel = bus.mode ? bus.w_i : w_act;

    generate
        if (SIGNED) begin : g_smul
            assign prod     = $signed(bus.act_i) * $signed(w_sel);
            assign prod_ext = PWIDTH'($signed(prod));
        end else begin : g_umul
            assign prod     = bus.act_i * w_sel;
            assign prod_ext = PWIDTH'(prod);
        end
    endgenerate

    assign ws_addend = bus.act_vld_i ? prod_ext : '0;
    assign ws_sum    = add_chk(bus.psum_i, ws_addend);
    assign acc_sum   = add_chk(acc, prod_ext);

    // A drain start also restarts the accumulator. The old value is already
    // on its way out through psum_o.
    assign restart = bus.clr_acc || (state == ST_ACC && bus.drain_i);

    always_comb begin
        state_nxt = state;
        psum_nxt  = psum_q;
        pvld_nxt  = pvld_q;
        acc_nxt   = acc;
        ovf_nxt   = bus.clr_acc ? 1'b0 : ovf_q;
        if (!bus.mode) begin
            state_nxt = ST_ACC;
            psum_nxt  = ws_sum[PWIDTH-1:0];
            pvld_nxt  = bus.act_vld_i | bus.psum_vld_i;
            ovf_nxt   = ovf_nxt | ws_sum[PWIDTH];
        end else begin
            if (restart) begin
                acc_nxt = bus.act_vld_i ? prod_ext : '0;
            end else if (bus.act_vld_i) begin
                acc_nxt = acc_sum[PWIDTH-1:0];
                ovf_nxt = ovf_nxt | acc_sum[PWIDTH];
            end
            case (state)
                ST_ACC: begin
                    pvld_nxt = 1'b0;
                    if (bus.drain_i) begin
                        psum_nxt  = acc;
                        pvld_nxt  = 1'b1;
                        state_nxt = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Pass the rows above through. The first invalid slot
                    // means the column above has finished draining.
                    psum_nxt = bus.psum_i;
                    pvld_nxt = bus.psum_vld_i;
                    if (!bus.psum_vld_i)
                        state_nxt = ST_ACC;
                end
                default: state_nxt = ST_ACC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= ST_ACC;
            shadow    <= '0;
            w_act     <= '0;
            acc       <= '0;
            psum_q    <= '0;
            pvld_q    <= 1'b0;
            ovf_q     <= 1'b0;
            act_q     <= '0;
            act_vld_q <= 1'b0;
        end else if (bus.enable) begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            psum_q    <= psum_nxt;
            pvld_q    <= pvld_nxt;
            ovf_q     <= ovf_nxt;
            act_q     <= bus.act_i;
            act_vld_q <= bus.act_vld_i;
            // The swap reads the pre-edge shadow, so a shift and a swap in
            // the same cycle do not interfere with each other.
            if (bus.w_shift || bus.mode)
                shadow <= bus.w_i;
            if (bus.w_swap)
                w_act <= shadow;
        end
    end

    assign bus.act_o      = act_q;
    assign bus.act_vld_o  = act_vld_q;
    assign bus.psum_o     = psum_q;
    assign bus.psum_vld_o = pvld_q;
    assign bus.w_o        = shadow;
    assign bus.ovf_o      = ovf_q;
endmodule

// File: tb/tb_pe_cfg.sv
// tb_pe_cfg: directed bench for pe_cfg. The bench has three single PEs that
// share one stimulus stream:
//   ss: signed, saturating
//   us: unsigned, saturating
//   sw: signed, wrapping
// It also has a 3-row OS column (c0 at the top, c2 at the bottom).
// Expected values are queued when a step is driven. They are popped and
// compared one time unit after the next rising edge.
module tb_pe_cfg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, enable, mode, w_shift, w_swap, clr_acc, drain_i;
    logic [7:0] act_i, w_i;
    logic       act_vld_i, psum_vld_i;
    logic [23:0] psum_i;
    logic [7:0] col_act [3];
    logic       col_avld;

    pe_cfg_if #(.DWIDTH(8), .PWIDTH(24)) ss_if ();
    pe_cfg_if #(.DWIDTH(8), .PWIDTH(24)) us_if ();
    pe_cfg_if #(.DWIDTH(8), .PWIDTH(24)) sw_if ();
    pe_cfg_if #(.DWIDTH(8), .PWIDTH(24)) c0_if ();
    pe_cfg_if #(.DWIDTH(8), .PWIDTH(24)) c1_if ();
    pe_cfg_if #(.DWIDTH(8), .PWIDTH(24)) c2_if ();

    assign ss_if.enable = enable, ss_if.mode = mode, ss_if.w_shift = w_shift,
           ss_if.w_swap = w_swap, ss_if.clr_acc = clr_acc, ss_if.drain_i = drain_i,
           ss_if.act_i = act_i, ss_if.act_vld_i = act_vld_i, ss_if.psum_i = psum_i,
           ss_if.psum_vld_i = psum_vld_i, ss_if.w_i = w_i;
    assign us_if.enable = enable, us_if.mode = mode, us_if.w_shift = w_shift,
           us_if.w_swap = w_swap, us_if.clr_acc = clr_acc, us_if.drain_i = drain_i,
           us_if.act_i = act_i, us_if.act_vld_i = act_vld_i, us_if.psum_i = psum_i,
           us_if.psum_vld_i = psum_vld_i, us_if.w_i = w_i;
    assign sw_if.enable = enable, sw_if.mode = mode, sw_if.w_shift = w_shift,
           sw_if.w_swap = w_swap, sw_if.clr_acc = clr_acc, sw_if.drain_i = drain_i,
           sw_if.act_i = act_i, sw_if.act_vld_i = act_vld_i, sw_if.psum_i = psum_i,
           sw_if.psum_vld_i = psum_vld_i, sw_if.w_i = w_i;
    assign c0_if.enable = enable, c0_if.mode = mode, c0_if.w_shift = w_shift,
           c0_if.w_swap = w_swap, c0_if.clr_acc = clr_acc, c0_if.drain_i = drain_i,
           c0_if.act_i = col_act[0], c0_if.act_vld_i = col_avld, c0_if.psum_i = '0,
           c0_if.psum_vld_i = 1'b0, c0_if.w_i = 8'd1;
    assign c1_if.enable = enable, c1_if.mode = mode, c1_if.w_shift = w_shift,
           c1_if.w_swap = w_swap, c1_if.clr_acc = clr_acc, c1_if.drain_i = drain_i,
           c1_if.act_i = col_act[1], c1_if.act_vld_i = col_avld, c1_if.psum_i = c0_if.psum_o,
           c1_if.psum_vld_i = c0_if.psum_vld_o, c1_if.w_i = 8'd1;
    assign c2_if.enable = enable, c2_if.mode = mode, c2_if.w_shift = w_shift,
           c2_if.w_swap = w_swap, c2_if.clr_acc = clr_acc, c2_if.drain_i = drain_i,
           c2_if.act_i = col_act[2], c2_if.act_vld_i = col_avld, c2_if.psum_i = c1_if.psum_o,
           c2_if.psum_vld_i = c1_if.psum_vld_o, c2_if.w_i = 8'd1;

    pe_cfg #(.DWIDTH(8), .PWIDTH(24), .SIGNED(1'b1), .SATURATE(1'b1)) u_ss (.clk(clk), .reset_n(reset_n), .bus(ss_if));
    pe_cfg #(.DWIDTH(8), .PWIDTH(24), .SIGNED(1'b0), .SATURATE(1'b1)) u_us (.clk(clk), .reset_n(reset_n), .bus(us_if));
    pe_cfg #(.DWIDTH(8), .PWIDTH(24), .SIGNED(1'b1), .SATURATE(1'b0)) u_sw (.clk(clk), .reset_n(reset_n), .bus(sw_if));
    pe_cfg #(.DWIDTH(8), .PWIDTH(24), .SIGNED(1'b1), .SATURATE(1'b1)) u_c0 (.clk(clk), .reset_n(reset_n), .bus(c0_if));
    pe_cfg #(.DWIDTH(8), .PWIDTH(24), .SIGNED(1'b1), .SATURATE(1'b1)) u_c1 (.clk(clk), .reset_n(reset_n), .bus(c1_if));
    pe_cfg #(.DWIDTH(8), .PWIDTH(24), .SIGNED(1'b1), .SATURATE(1'b1)) u_c2 (.clk(clk), .reset_n(reset_n), .bus(c2_if));

    localparam int SS_PSUM = 0, SS_PVLD = 1, SS_ACT = 2, SS_AVLD = 3, SS_WO = 4, SS_OVF = 5;
    localparam int US_PSUM = 6, US_OVF = 7, SW_PSUM = 8, SW_OVF = 9, C2_PSUM = 10, C2_PVLD = 11;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            SS_PSUM: return {8'h0, ss_if.psum_o};
            SS_PVLD: return {31'h0, ss_if.psum_vld_o};
            SS_ACT:  return {24'h0, ss_if.act_o};
            SS_AVLD: return {31'h0, ss_if.act_vld_o};
            SS_WO:   return {24'h0, ss_if.w_o};
            SS_OVF:  return {31'h0, ss_if.ovf_o};
            US_PSUM: return {8'h0, us_if.psum_o};
            US_OVF:  return {31'h0, us_if.ovf_o};
            SW_PSUM: return {8'h0, sw_if.psum_o};
            SW_OVF:  return {31'h0, sw_if.ovf_o};
            C2_PSUM: return {8'h0, c2_if.psum_o};
            C2_PVLD: return {31'h0, c2_if.psum_vld_o};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic want(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare every expectation queued for it.
    task automatic step();
        exp_t        e;
        logic [31:0] o;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = obs(e.sel);
            n_cmp++;
            assert (o === e.exp) else begin
                n_bad++;
                $error("FAIL %s: got %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; mode = 1'b0; w_shift = 1'b0; w_swap = 1'b0;
        clr_acc = 1'b0; drain_i = 1'b0; act_i = '0; w_i = '0; act_vld_i = 1'b0;
        psum_i = '0; psum_vld_i = 1'b0; col_avld = 1'b0;
        col_act[0] = 8'd10; col_act[1] = 8'd20; col_act[2] = 8'd30;

        // Reset state
        step();
        want("rst_psum", SS_PSUM, 0); want("rst_pvld", SS_PVLD, 0); want("rst_act", SS_ACT, 0);
        want("rst_wo", SS_WO, 0); want("rst_ovf", SS_OVF, 0); want("rst_col_vld", C2_PVLD, 0);
        step();

        // WS basic: shadow gets 3, swap, then 5*3+100
        reset_n = 1'b1; w_i = 8'd3; w_shift = 1'b1;
        want("ws_wo_lag", SS_WO, 3);
        step();
        w_shift = 1'b0; w_swap = 1'b1;
        step();
        w_swap = 1'b0; act_i = 8'd5; act_vld_i = 1'b1; psum_i = 24'd100; psum_vld_i = 1'b1;
        want("ws_psum", SS_PSUM, 115); want("ws_pvld", SS_PVLD, 1);
        want("ws_act", SS_ACT, 5); want("ws_avld", SS_AVLD, 1); want("ws_psum_u", US_PSUM, 115);
        step();

        // Signed/unsigned extremes: 0x80*0x80, then 0xFF*0xFF
        act_vld_i = 1'b0; psum_vld_i = 1'b0; psum_i = '0; w_i = 8'h80; w_shift = 1'b1;
        step();
        w_shift = 1'b0; w_swap = 1'b1;
        step();
        w_swap = 1'b0; act_i = 8'h80; act_vld_i = 1'b1; psum_vld_i = 1'b1;
        want("m128_s", SS_PSUM, 16384); want("m128_u", US_PSUM, 16384);
        step();
        act_vld_i = 1'b0; w_i = 8'hFF; w_shift = 1'b1;
        step();
        w_shift = 1'b0; w_swap = 1'b1;
        step();
        w_swap = 1'b0; act_i = 8'hFF; act_vld_i = 1'b1;
        want("ff_s", SS_PSUM, 1); want("ff_u", US_PSUM, 65025);
        step();

        // Saturation/wrap at the positive edge of the range, then unsigned top
        act_vld_i = 1'b0; w_i = 8'd4; w_shift = 1'b1;
        step();
        w_shift = 1'b0; w_swap = 1'b1;
        step();
        w_swap = 1'b0; act_i = 8'd4; act_vld_i = 1'b1; psum_i = 24'h7FFFF8;
        want("sat_s", SS_PSUM, 32'h7FFFFF); want("sat_s_ovf", SS_OVF, 1);
        want("sat_u_inrange", US_PSUM, 32'h800008); want("sat_u_ovf0", US_OVF, 0);
        want("wrap_s", SW_PSUM, 32'h800008); want("wrap_s_ovf", SW_OVF, 1);
        step();
        psum_i = 24'hFFFFF8;
        want("sat_u", US_PSUM, 32'hFFFFFF); want("sat_u_ovf", US_OVF, 1);
        want("neg8_s", SS_PSUM, 8); want("neg8_w", SW_PSUM, 8); want("ovf_sticky", SS_OVF, 1);
        step();
        act_vld_i = 1'b0; psum_vld_i = 1'b0; psum_i = '0;
        want("ovf_hold", SS_OVF, 1); want("ws_vld0", SS_PVLD, 0);
        step();
        clr_acc = 1'b1;
        want("ovf_clr_s", SS_OVF, 0); want("ovf_clr_w", SW_OVF, 0);
        step();

        // OS accumulate: 2*3 + 4*5 + (-1)*7 = 19, then drain
        mode = 1'b1; act_i = 8'd2; w_i = 8'd3; act_vld_i = 1'b1;
        step();
        clr_acc = 1'b0; act_i = 8'd4; w_i = 8'd5;
        step();
        act_i = 8'hFF; w_i = 8'd7;
        want("os_wo_follows", SS_WO, 7);
        step();
        act_vld_i = 1'b0; drain_i = 1'b1;
        want("os_drain_psum", SS_PSUM, 19); want("os_drain_vld", SS_PVLD, 1);
        step();
        drain_i = 1'b0;
        want("os_after_vld", SS_PVLD, 0);
        step();
        want("os_acc_vld", SS_PVLD, 0);
        step();

        // Reset in the middle of a drain
        clr_acc = 1'b1; act_i = 8'd2; w_i = 8'd3; act_vld_i = 1'b1;
        step();
        clr_acc = 1'b0; act_vld_i = 1'b0; drain_i = 1'b1;
        want("pre_rst_psum", SS_PSUM, 6); want("pre_rst_vld", SS_PVLD, 1);
        step();
        reset_n = 1'b0; drain_i = 1'b0;
        want("rst_mid_psum", SS_PSUM, 0); want("rst_mid_vld", SS_PVLD, 0);
        want("rst_mid_wo", SS_WO, 0); want("rst_mid_act", SS_ACT, 0);
        step();
        // Back in ACC: a new drain must start and emit the cleared acc
        reset_n = 1'b1; drain_i = 1'b1;
        want("rst_acc_drain_vld", SS_PVLD, 1); want("rst_acc_drain_psum", SS_PSUM, 0);
        step();
        drain_i = 1'b0;
        step();

        // Shift and swap in the same cycle
        mode = 1'b0; w_i = 8'd9; w_shift = 1'b1;
        want("ovl_wo9", SS_WO, 9);
        step();
        w_i = 8'd11; w_swap = 1'b1;
        want("ovl_wo11", SS_WO, 11);
        step();
        w_shift = 1'b0; w_swap = 1'b0; act_i = 8'd2; act_vld_i = 1'b1; psum_vld_i = 1'b1;
        want("ovl_active_old", SS_PSUM, 18);
        step();
        act_vld_i = 1'b0; psum_vld_i = 1'b0;

        // Column drain: accs 10/20/30 come out bottom-first
        mode = 1'b1; clr_acc = 1'b1; col_avld = 1'b1;
        step();
        clr_acc = 1'b0; col_avld = 1'b0; drain_i = 1'b1;
        want("col_d0", C2_PSUM, 30); want("col_v0", C2_PVLD, 1);
        step();
        drain_i = 1'b0;
        want("col_d1", C2_PSUM, 20); want("col_v1", C2_PVLD, 1);
        step();
        want("col_d2", C2_PSUM, 10); want("col_v2", C2_PVLD, 1);
        step();
        want("col_end", C2_PVLD, 0);
        step();

        // Same drain with enable low for two cycles after the first word
        clr_acc = 1'b1; col_avld = 1'b1;
        step();
        clr_acc = 1'b0; col_avld = 1'b0; drain_i = 1'b1;
        want("cole_d0", C2_PSUM, 30); want("cole_v0", C2_PVLD, 1);
        step();
        drain_i = 1'b0; enable = 1'b0;
        want("cole_hold1", C2_PSUM, 30); want("cole_hv1", C2_PVLD, 1);
        step();
        want("cole_hold2", C2_PSUM, 30); want("cole_hv2", C2_PVLD, 1);
        step();
        enable = 1'b1;
        want("cole_d1", C2_PSUM, 20);
        step();
        want("cole_d2", C2_PSUM, 10); want("cole_v2", C2_PVLD, 1);
        step();
        want("cole_end", C2_PVLD, 0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pe_cfg.md
# pe_cfg

Configurable processing element for the next-generation systolic array. It supports two dataflows, selected at runtime:
- Weight-stationary (WS): partial sums flow down the column.
- Output-stationary (OS): the PE accumulates locally and drains results down the column on command.

Adds over the first-generation PE: a parametrised psum width, signed/unsigned arithmetic, saturation with a sticky overflow flag, a double-buffered weight register fed by a shift chain, and valid tracking.

## Interface
- DWIDTH, 8, operand width (activation and weight).
- PWIDTH, 24, psum/accumulator width; must be >= 2*DWIDTH.
- SIGNED, 1, 1 = two's-complement operands and psum; 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^PWIDTH.
- clk  in  1  clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  clock enable; when low every register holds.
- mode  in  1  0 = WS, 1 = OS.
- act_i / act_vld_i  in  DWIDTH / 1  activation from the left and its valid.
- act_o / act_vld_o  out  DWIDTH / 1  registered copy of act_i / act_vld_i, to the right.
- psum_i / psum_vld_i  in  PWIDTH / 1  psum from above and its valid.
- psum_o / psum_vld_o  out  PWIDTH / 1  psum to below and its valid.
- w_i  in  DWIDTH  weight-chain input from above.
- w_o  out  DWIDTH  shadow weight register, to below.
- w_shift  in  1  WS: shadow <= w_i.
- w_swap  in  1  active weight <= shadow.
- clr_acc  in  1  OS: restart the accumulation.
- drain_i  in  1  OS: start a drain (broadcast to the whole column).
- ovf_o  out  1  sticky overflow/saturation flag.

## Operation
- Reset values: all outputs, shadow, active weight and accumulator are 0; state = ACC.
- product = act_i * w (signed or unsigned per SIGNED), extended to PWIDTH.
  - w = active weight in WS mode; w = w_i in OS mode.
- Additions are computed at PWIDTH+1 bits.
  - SATURATE=1: clamp to [-2^(PWIDTH-1), 2^(PWIDTH-1)-1] when signed, or [0, 2^PWIDTH-1] when unsigned.
  - SATURATE=0: truncate.
  - Either way, an out-of-range result sets ovf_o.
- ovf_o clears only on reset or clr_acc.
- Every enabled cycle, in both modes:
  - act_o <= act_i; act_vld_o <= act_vld_i.
- Shadow weight register:
  - loads w_i when (w_shift | mode);
  - w_o = shadow, so w_o lags w_i by one cycle.
- w_swap: active weight <= shadow, using the pre-edge shadow value. With w_shift in the same cycle, the swap takes the old shadow and the shadow takes w_i.
- WS mode (state is held at ACC):
  - psum_o <= psum_i + (act_vld_i ? product : 0)
  - psum_vld_o <= act_vld_i | psum_vld_i
  - clr_acc and drain_i are ignored.
- OS mode, accumulator:
  - In ACC and in DRAIN, act_vld_i gives acc <= acc + product.
  - clr_acc or a drain start overrides this with acc <= (act_vld_i ? product : 0).
- OS mode, state machine:
  - ACC: psum_vld_o <= 0. If drain_i: psum_o <= acc, psum_vld_o <= 1, go to DRAIN.
  - DRAIN: psum_o <= psum_i; psum_vld_o <= psum_vld_i. When psum_vld_i == 0, go to ACC. drain_i is ignored while in DRAIN.
- Column drain behaviour: with drain_i broadcast to all N PEs, the bottom PE emits acc[N-1], acc[N-2], …, acc[0] on N consecutive cycles, then valid 0. The row-r PE returns to ACC r+1 cycles after the drain.
- mode == 0 in any cycle forces the next state to ACC. Mode changes are legal only between tiles; in-flight data is not preserved.

## Timing
- Latency of 1 cycle for every path:
  - act_i → act_o
  - psum_i → psum_o (WS)
  - w_i → w_o
  - drain_i → first psum_vld_o
- New weight chain load: with N rows, apply N w_shift cycles (bottom row's weight first), then one w_swap. The swapped weight is used by the product in the cycle after the w_swap edge.
- Activations may stream back-to-back during w_shift, because the active weight is unaffected until the swap.
- enable low freezes state, outputs and flags. Sampled inputs are dropped.
- reset_n low mid-drain: the next edge returns everything to reset values, and the drain sequence is abandoned.

## Test plan
- WS basic: w_shift with w_i=3, then w_swap; act_i=5 valid, psum_i=100 valid → next cycle psum_o=115, psum_vld_o=1, act_o=5.
- Signed extreme: SIGNED=1, weight -128, act_i=-128, psum_i=0 → psum_o=16384. Repeat with SIGNED=0, 0x80*0x80 → 16384; 0xFF*0xFF → 65025.
- Saturation: PWIDTH=24, weight 4, act 4, psum_i=8388600 → psum_o=8388607 and ovf_o=1, held until clr_acc. With SATURATE=0 → psum_o=-8388600 (wrapped), ovf_o=1.
- OS accumulate/drain: pairs (2,3), (4,5), (-1,7) with clr_acc on the first pair → acc=19. drain_i → psum_o=19 with valid for 1 cycle, then state returns to ACC.
- Column drain (3 PEs, accs 10, 20, 30 top to bottom): bottom psum_o = 30, 20, 10 on consecutive cycles, then psum_vld_o=0. Repeat with enable low for 2 cycles mid-drain → same sequence, stretched by 2 cycles.
- Reset mid-drain and shadow/swap overlap:
  - reset_n low during drain → all outputs 0 next cycle, state ACC.
  - w_shift and w_swap together → active gets the old shadow, w_o gets the new w_i.
